down_counter: RTL

DOWN_COUNTER -- requirements
Module: down_counter

---
 rtl/down_counter_pkg.sv | 12 +
 rtl/down_counter_if.sv | 15 +
 rtl/down_counter_dff_ar.sv | 18 +
 rtl/down_counter.sv | 102 ++++++++++
 4 files changed

// File: rtl/down_counter_pkg.sv
// down_counter_pkg: shared state encoding and default width for down_counter.
package down_counter_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/down_counter_if.sv
// down_counter_if: load/enable request side and count/status response side.
interface down_counter_if #(
  parameter int WIDTH = down_counter_pkg::DEF_WIDTH
);
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic [WIDTH-1:0] count;
  logic             zero;
  logic             busy;
  logic             done;

  modport master (output load, load_val, en, input count, zero, busy, done);
  modport slave  (input load, load_val, en, output count, zero, busy, done);
endinterface

// File: rtl/down_counter_dff_ar.sv
// dff_ar: single-bit D flop, async active-low clear, true and inverted outputs.
module dff_ar (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic q_n
);

  // capture d each rising edge, clear immediately on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= 1'b0;
    else        q <= d;
  end

  assign q_n = ~q;

endmodule

// File: rtl/down_counter.sv
// down_counter: loadable down counter with IDLE/RUN/DONE control.
// Optional feature macro: DOWN_COUNTER_AUTO_RELOAD_EN -- DONE restarts the
// countdown from the last loaded value instead of returning to IDLE.
module down_counter
  import down_counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic           clk,
  input logic           rst_n,
  down_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_n;
  logic [WIDTH-1:0] cnt_q, cnt_qn, cnt_n;
  logic [WIDTH-1:0] rld_val;
  logic             busy_q, done_q;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] rld_q;

  // remember the most recent load value for restarting after terminal count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        rld_q <= '0;
    else if (bus.load) rld_q <= bus.load_val;
  end

  assign rld_val = rld_q;
`else
  assign rld_val = '0;
`endif

  // next count and next state: load first, then decrement/hold per state
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    if (bus.load) begin
      cnt_n   = bus.load_val;
      state_n = (bus.load_val != '0) ? RUN : DONE;
    end else begin
      case (state_q)
        IDLE: ;
        RUN: begin
          if (bus.en) begin
            // saturate at zero; reaching zero ends the countdown
            if (cnt_q == ONE || cnt_q == '0) begin
              cnt_n   = '0;
              state_n = DONE;
            end else begin
              cnt_n = cnt_q - ONE;
            end
          end
        end
        DONE: begin
          if (rld_val != '0) begin
            cnt_n   = rld_val;
            state_n = RUN;
          end else begin
            cnt_n   = '0;
            state_n = IDLE;
          end
        end
        default: begin
          cnt_n   = '0;
          state_n = IDLE;
        end
      endcase
    end
  end

  // state plus registered status; done trails the DONE state by one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      busy_q  <= (state_n == RUN);
      done_q  <= (state_q == DONE);
    end
  end

  // count register built bitwise from flops
  for (genvar i = 0; i < WIDTH; i++) begin : g_cnt
    dff_ar u_bit (
      .clk  (clk),
      .rst_n(rst_n),
      .d    (cnt_n[i]),
      .q    (cnt_q[i]),
      .q_n  (cnt_qn[i])
    );
  end

  assign bus.count = cnt_q;
  assign bus.zero  = &cnt_qn;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule
